// File: rtl/eql_cmp_ser.sv
// Serial masked equality comparator: compares CHUNK bits per clock, LSB chunk first, behind valid/ready handshakes.
// Optional macro EQL_CMP_SER_EARLY_EXIT_EN finishes at the first chunk that contains a mismatch.
module eql_cmp_ser #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    localparam int unsigned N  = (CHUNK == 0 || CHUNK > WIDTH) ? 1 : WIDTH / CHUNK,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [WIDTH-1:0] req_val,
    input  logic [WIDTH-1:0] req_rfr,
    input  logic [WIDTH-1:0] req_msk,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic             rsp_eql,
    output logic [CW-1:0]    rsp_cnt
);

    if (CHUNK == 0) begin : g_chk_zero
        $error("eql_cmp_ser: CHUNK must be non-zero");
    end else if (WIDTH % CHUNK != 0) begin : g_chk_mult
        $error("eql_cmp_ser: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  diff_q;
    logic              acc_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_inc_c;
    logic              mismatch_c;
    logic              last_c;
    logic              fin_c;
    logic              xfer_c;

    // Only the masked difference is kept; it is shifted down one chunk per cycle.
    assign mismatch_c = |diff_q[CHUNK-1:0];
    assign cnt_inc_c  = cnt_q + CW'(1);
    assign last_c     = (cnt_q == CW'(N - 1));
`ifdef EQL_CMP_SER_EARLY_EXIT_EN
    assign fin_c      = last_c | mismatch_c;
`else
    assign fin_c      = last_c;
`endif
    assign req_rdy    = (state == IDLE) && !rst;
    assign xfer_c     = req_vld & req_rdy;
    assign rsp_vld    = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer_c) state_nxt = BUSY;
            BUSY:    if (fin_c) state_nxt = DONE;
            DONE:    if (rsp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, per-chunk accumulate, latch the response on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            rsp_eql <= 1'b0;
            rsp_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer_c) begin
                        diff_q <= (req_val ^ req_rfr) & req_msk;
                        acc_q  <= 1'b1;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    diff_q <= diff_q >> CHUNK;
                    acc_q  <= acc_q & ~mismatch_c;
                    cnt_q  <= cnt_inc_c;
                    if (fin_c) begin
                        rsp_eql <= acc_q & ~mismatch_c;
                        rsp_cnt <= cnt_inc_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eql_cmp_ser.sv
// Scoreboard bench for eql_cmp_ser (WIDTH=32, CHUNK=8); expectations follow EQL_CMP_SER_EARLY_EXIT_EN when defined.
module tb_eql_cmp_ser;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int N = 4;
`ifdef EQL_CMP_SER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_vld;
    logic              req_rdy;
    logic [WIDTH-1:0]  req_val;
    logic [WIDTH-1:0]  req_rfr;
    logic [WIDTH-1:0]  req_msk;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic              rsp_eql;
    logic [2:0]        rsp_cnt;

    eql_cmp_ser #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_val (req_val),
        .req_rfr (req_rfr),
        .req_msk (req_msk),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_eql (rsp_eql),
        .rsp_cnt (rsp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic eql;
        int   cnt;
        int   lat;
        int   acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   vld_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on rsp_vld rise, payload on handshake
    always @(negedge clk) begin
        if (rst) begin
            vld_seen = 1'b0;
        end else if (rsp_vld) begin
            if (!vld_seen) begin
                vld_seen = 1'b1;
                if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
                else chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
            end
            if (rsp_rdy && sb.size() != 0) begin
                chk("rsp_eql", rsp_eql, sb[0].eql);
                chk("rsp_cnt", rsp_cnt, sb[0].cnt);
                void'(sb.pop_front());
                vld_seen = 1'b0;
            end
        end
    end

    // Issue one request; leaves req_vld high with scrambled operands after the accept edge
    task automatic send(input logic [31:0] v, input logic [31:0] r, input logic [31:0] m,
                        input bit e_eql, input int ee_cnt, input bit push, output int acc_at);
        int t;
        int c;
        t = 0;
        req_vld = 1'b1;
        req_val = v;
        req_rfr = r;
        req_msk = m;
        while (!req_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_rdy) begin
            chk("accept_timeout", 0, 1);
            acc_at = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_at = cyc;
        if (push) begin
            c = EE ? ee_cnt : N;
            sb.push_back('{e_eql, c, c, acc_at});
        end
        req_val = ~v;
        req_rfr = v ^ 32'h5a5a_5a5a;
        req_msk = '1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    logic [31:0] tv [8] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'h0000_1200, 32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5};
    logic [31:0] tr [8] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                            32'h0000_1300, 32'hDE5D_BEEF, 32'h1234_5679, 32'h25A5_A5A5};
    logic [31:0] tm [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000,
                            32'hFFFF_FFFF, 32'hFF0F_FFFF, 32'hFFFF_FF00, 32'hFFFF_FFFF};
    bit          te [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int          tc [8] = '{4, 1, 4, 4, 2, 4, 4, 4};

    initial begin
        int a1;
        int a2;
        int t;
        int r_cyc;
        rst = 1'b1;
        req_vld = 1'b0;
        req_val = '0;
        req_rfr = '0;
        req_msk = '0;
        rsp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_vld", rsp_vld, 0);
        chk("reset_rsp_eql", rsp_eql, 0);
        chk("reset_rsp_cnt", rsp_cnt, 0);
        chk("reset_req_rdy", req_rdy, 0);
        rst = 1'b0;
        #1;
        chk("idle_req_rdy", req_rdy, 1);
        @(negedge clk);

        // Directed vectors, one at a time
        for (int i = 0; i < 8; i++) begin
            send(tv[i], tr[i], tm[i], te[i], tc[i], 1'b1, a1);
            req_vld = 1'b0;
            wait_idle();
        end

        // Response backpressure with req_vld held high
        rsp_rdy = 1'b0;
        send(32'hCAFE_0000, 32'hCAFE_0000, 32'hFFFF_FFFF, 1'b1, 4, 1'b1, a1);
        t = 0;
        while (!rsp_vld && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_vld", rsp_vld, 1);
            chk("bp_rsp_eql", rsp_eql, 1);
            chk("bp_rsp_cnt", rsp_cnt, 4);
            chk("bp_req_rdy", req_rdy, 0);
            @(negedge clk);
        end
        rsp_rdy = 1'b1;
        r_cyc = cyc;
        send(32'h0F0F_0F0F, 32'h0F0F_0F0E, 32'hFFFF_FFFF, 1'b0, 1, 1'b1, a2);
        chk("bp_accept_gap", a2 - r_cyc, 2);
        req_vld = 1'b0;
        wait_idle();

        // Equal response so reset visibly clears rsp_eql/rsp_cnt
        send(32'h1111_2222, 32'h1111_2222, 32'hFFFF_FFFF, 1'b1, 4, 1'b1, a1);
        req_vld = 1'b0;
        wait_idle();

        // Reset during chunk 2
        send(32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 4, 1'b0, a1);
        req_vld = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rsp_vld", rsp_vld, 0);
        chk("rst_mid_rsp_eql", rsp_eql, 0);
        chk("rst_mid_rsp_cnt", rsp_cnt, 0);
        chk("rst_mid_req_rdy", req_rdy, 0);
        rst = 1'b0;
        #1;
        chk("rst_mid_req_rdy_after", req_rdy, 1);
        repeat (N + 4) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_vld, 0);

        // Back-to-back with req_vld held high
        send(32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 4, 1'b1, a1);
        send(32'h0100_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 4, 1'b1, a2);
        chk("b2b_accept_gap", a2 - a1, N + 2);
        req_vld = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
